// File: rtl/fetch_unit.sv
// Instruction fetch stage (Q1). Owns the program counter, issues word fetches over a
// request/grant, in-order-response memory port, buffers returned words with their PCs in a
// small FIFO and hands them to Q1/Q2 under valid/ready. A redirect flushes the FIFO and
// marks every outstanding response as stale so it is dropped on arrival.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction memory port
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  // Redirect from Q2 (JAL) / Q4 (taken branch)
  input  logic        redirect_ip,
  input  logic [31:0] redirect_pc_ip,
  // Q1/Q2 pipeline register
  output logic        instr_valid_op,
  output logic [31:0] instr_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc_incr_op,
  input  logic        instr_ready_ip
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  // Fetch address and FIFO storage
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic [31:0]      instr_q  [DEPTH];
  logic [31:0]      instr_d  [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  // head: oldest allocated, tail: next to allocate, fill: oldest allocated but unfilled
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW-1:0]  fill_q, fill_d;

  // alloc: allocated entries, pend: allocated but unfilled, drop: stale responses owed
  logic [CntW-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CntW-1:0]  pend_cnt_q, pend_cnt_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CntW:0]    occupancy;
  logic             grant;
  logic             pop;
  logic             fill;
  logic             stale_rsp;

  // Only the word address of the redirect target is used.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_ip[1:0];

  // Request side and handshakes; req never looks at gnt or ready
  always_comb begin
    occupancy   = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    imem_req_op = rst_n && (occupancy < DepthOcc) && !redirect_ip;
    imem_addr_op = fetch_pc_q;
    grant       = imem_req_op && imem_gnt_ip;
    pop         = instr_valid_op && instr_ready_ip;
    stale_rsp   = imem_rvalid_ip && (drop_cnt_q != '0);
    fill        = imem_rvalid_ip && (drop_cnt_q == '0) && (pend_cnt_q != '0);
  end

  // Head entry drives the pipeline register; all of it comes from flops
  always_comb begin
    instr_valid_op = (alloc_cnt_q != '0) && filled_q[head_q];
    instr_op       = instr_q[head_q];
    pc_op          = pc_q[head_q];
    pc_incr_op     = pc_q[head_q] + 32'd4;
  end

  // Next-state: redirect overrides grant, fill and pop
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (redirect_ip) begin
      fetch_pc_d  = {redirect_pc_ip[31:2], 2'b00};
      filled_d    = '0;
      head_d      = '0;
      tail_d      = '0;
      fill_d      = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      // Every unfilled entry still has a response coming; a response arriving now is
      // either already counted in drop or is one of those unfilled entries.
      drop_cnt_d  = drop_cnt_q + pend_cnt_q - CntW'(imem_rvalid_ip);
    end else begin
      if (grant) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PtrW'(1);
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end
      if (fill) begin
        instr_d[fill_q]  = imem_rdata_ip;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PtrW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PtrW'(1);
      end
      if (stale_rsp) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CntW'(grant) - CntW'(pop);
      pend_cnt_d  = pend_cnt_q + CntW'(grant) - CntW'(fill);
    end
  end

  // State registers; storage is cleared too so the head reads as zero in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      filled_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= pc_d[i];
        instr_q[i] <= instr_d[i];
      end
    end
  end

  // Internal invariants and memory-side protocol expectations
  addr_aligned_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_op |-> (imem_addr_op[1:0] == 2'b00));

  addr_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_op && !imem_gnt_ip) |=> $stable(imem_addr_op));

  rsp_owed_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_ip |-> ((drop_cnt_q != '0) || (pend_cnt_q != '0)));

  occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= DepthOcc);

  pend_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    pend_cnt_q <= alloc_cnt_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable in-order memory, an
// independent fetch-address model and a scoreboard of expected {pc, instr} pairs that is
// filled on every grant, flushed on redirect/reset and drained on every handshake.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0100;
  localparam logic [31:0] WrapPc  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, rvalid, redirect, valid, ready;
  logic [31:0] addr, rdata, redirect_pc, instr, pc, pc_incr;

  // Second instance only exercises the 32-bit PC wrap out of reset
  logic        req_w, rvalid_w, valid_w;
  logic [31:0] addr_w, rdata_w, instr_w, pc_w, pc_incr_w;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(ResetPc), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_op    (req),
    .imem_addr_op   (addr),
    .imem_gnt_ip    (gnt),
    .imem_rvalid_ip (rvalid),
    .imem_rdata_ip  (rdata),
    .redirect_ip    (redirect),
    .redirect_pc_ip (redirect_pc),
    .instr_valid_op (valid),
    .instr_op       (instr),
    .pc_op          (pc),
    .pc_incr_op     (pc_incr),
    .instr_ready_ip (ready)
  );

  fetch_unit #(.RESET_PC(WrapPc), .DEPTH(4)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_op    (req_w),
    .imem_addr_op   (addr_w),
    .imem_gnt_ip    (1'b1),
    .imem_rvalid_ip (rvalid_w),
    .imem_rdata_ip  (rdata_w),
    .redirect_ip    (1'b0),
    .redirect_pc_ip (32'h0),
    .instr_valid_op (valid_w),
    .instr_op       (instr_w),
    .pc_op          (pc_w),
    .pc_incr_op     (pc_incr_w),
    .instr_ready_ip (1'b1)
  );

  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct {logic [31:0] addr; int unsigned due;} mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  int unsigned gnt_cnt  = 0;
  int unsigned pop_cnt  = 0;
  logic [31:0] model_pc = ResetPc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor, scoreboard and memory bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      model_pc   = ResetPc;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(valid), 32'd1);
        check_eq("stall_pc", pc, prev_pc);
        check_eq("stall_instr", instr, prev_instr);
      end
      if (valid && ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("sb_pop_when_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sb_pc", pc, e.pc);
          check_eq("sb_instr", instr, e.instr);
          check_eq("sb_pc_incr", pc_incr, e.pc + 32'd4);
        end
      end
      if (redirect) begin
        check_eq("req_in_redirect", 32'(req), 32'd0);
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (req && gnt) begin
        check_eq("gnt_addr", addr, model_pc);
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
        gnt_cnt++;
      end
      if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (req && gnt) mem_q.push_back('{addr: addr, due: cyc + lat});
      prev_stall = valid && !ready && !redirect;
      prev_pc    = pc;
      prev_instr = instr;
    end
    cyc++;
  end

  // Memory response driver: in order, 'lat' cycles after the grant
  always begin
    @(posedge clk);
    #1;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(mem_q[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end

  // Wrap instance memory: always grants, one-cycle latency
  logic        w_fire = 1'b0;
  logic [31:0] w_addr = 32'h0;
  always @(negedge clk) begin
    w_fire = rst_n && req_w;
    w_addr = addr_w;
  end
  always begin
    @(posedge clk);
    #1;
    rvalid_w = rst_n && w_fire;
    rdata_w  = mem_word(w_addr);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reset for two cycles with the given memory latency and ready level, then release
  task automatic do_reset(input int unsigned latency, input logic rdy);
    rst_n    = 1'b0;
    lat      = latency;
    ready    = rdy;
    redirect = 1'b0;
    gnt      = 1'b1;
    tick(2);
    rst_n = 1'b1;
    #1;
    check_eq("rel_req", 32'(req), 32'd1);
    check_eq("rel_addr", addr, ResetPc);
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!valid && cycles < 30) begin
      tick();
      cycles++;
    end
    check_eq(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    int          n;
    int unsigned p0, g0;
    rst_n       = 1'b1;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    gnt         = 1'b1;
    rvalid      = 1'b0;
    rdata       = 32'h0;
    rvalid_w    = 1'b0;
    rdata_w     = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc_incr", pc_incr, 32'h4);

    // Reset and stream, plus the wrap instance alongside
    do_reset(1, 1'b1);
    check_eq("rel_valid", 32'(valid), 32'd0);
    tick();
    check_eq("first_valid_c1", 32'(valid), 32'd0);
    tick();
    check_eq("first_valid_c2", 32'(valid), 32'd1);
    check_eq("first_pc", pc, ResetPc);
    check_eq("wrap_valid", 32'(valid_w), 32'd1);
    check_eq("wrap_pc0", pc_w, 32'hFFFF_FFF8);
    tick();
    check_eq("wrap_pc1", pc_w, 32'hFFFF_FFFC);
    check_eq("wrap_incr1", pc_incr_w, 32'h0);
    check_eq("wrap_instr1", instr_w, mem_word(32'hFFFF_FFFC));
    tick();
    check_eq("wrap_pc2", pc_w, 32'h0);
    check_eq("wrap_incr2", pc_incr_w, 32'h4);
    p0 = pop_cnt;
    tick(8);
    check_eq("stream_pops", 32'(pop_cnt - p0), 32'd8);

    // Backpressure from reset: exactly DEPTH grants, then drain in order
    do_reset(1, 1'b0);
    g0 = gnt_cnt;
    tick(10);
    check_eq("bp_grants", 32'(gnt_cnt - g0), 32'd4);
    check_eq("bp_req_low", 32'(req), 32'd0);
    check_eq("bp_valid", 32'(valid), 32'd1);
    check_eq("bp_pc", pc, ResetPc);
    check_eq("bp_instr", instr, mem_word(ResetPc));
    ready = 1'b1;
    p0 = pop_cnt;
    tick(12);
    check_eq("bp_drain_pops", 32'(pop_cnt - p0), 32'd12);

    // Redirect with three responses in flight (latency 3)
    do_reset(3, 1'b1);
    tick(3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    #1;
    check_eq("rd_req_low", 32'(req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("rd_req_next", 32'(req), 32'd1);
    check_eq("rd_addr_next", addr, 32'h0000_2000);
    wait_valid("rd_valid_timeout", n);
    check_eq("rd_first_pc", pc, 32'h0000_2000);
    check_eq("rd_first_instr", instr, mem_word(32'h0000_2000));
    check_eq("rd_latency", 32'(n), 32'd4);

    // Redirect in a cycle that also pops and receives a response
    do_reset(1, 1'b1);
    tick(6);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    p0 = pop_cnt;
    tick();
    redirect = 1'b0;
    check_eq("rp_valid_n1", 32'(valid), 32'd0);
    #1;
    check_eq("rp_req_n1", 32'(req), 32'd1);
    check_eq("rp_addr_n1", addr, 32'h0000_3000);
    tick();
    check_eq("rp_valid_n2", 32'(valid), 32'd0);
    tick();
    check_eq("rp_valid_n3", 32'(valid), 32'd1);
    check_eq("rp_pc_n3", pc, 32'h0000_3000);
    check_eq("rp_pops", 32'(pop_cnt - p0), 32'd1);
    tick(4);

    // Back-to-back redirects: the second target wins
    do_reset(2, 1'b1);
    tick(4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    tick();
    redirect_pc = 32'h0000_6006;
    #1;
    check_eq("bb_req_low", 32'(req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("bb_addr", addr, 32'h0000_6004);
    wait_valid("bb_valid_timeout", n);
    check_eq("bb_pc", pc, 32'h0000_6004);
    tick(6);

    // Mid-run asynchronous reset with two buffered and two outstanding
    do_reset(3, 1'b0);
    g0 = gnt_cnt;
    tick(5);
    check_eq("mr_pre_valid", 32'(valid), 32'd1);
    check_eq("mr_pre_grants", 32'(gnt_cnt - g0), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_valid_drop", 32'(valid), 32'd0);
    check_eq("mr_req_drop", 32'(req), 32'd0);
    do_reset(1, 1'b1);
    check_eq("mr_empty", 32'(valid), 32'd0);
    tick(2);
    check_eq("mr_restart_valid", 32'(valid), 32'd1);
    check_eq("mr_restart_pc", pc, ResetPc);
    tick(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

endmodule
